// File: rtl/panel_pkg.sv
// Shared constants and types for the front-panel SPI display target.
package panel_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] ID_BYTE = 8'h5A;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADR  = 3'd2;
    localparam logic [2:0] S_SEG  = 3'd3;
    localparam logic [2:0] S_ATTR = 3'd4;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] attr;
    } digit_t;

endpackage

// File: rtl/panel_spi_target_shift.sv
// SPI mode-0 bit engine: pin synchronisers, edge detect, rx/tx shift registers.
module spi_target_shift
    import panel_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       ss_n_i,
    input  logic [7:0] tx_byte_i,
    output logic       miso_o,
    output logic       ss_active_o,
    output logic       ss_fall_o,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o
);

    logic [1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic       sclk_prev_q, ss_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       sclk_s, mosi_s, ss_n_s;
    logic       sclk_rise, sclk_fall;

    // ss flops come out of reset at the idle level so no phantom frame starts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            ss_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            ss_sync_q   <= {ss_sync_q[0], ss_n_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_n_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
        end
    end

    assign sclk_s       = sclk_sync_q[1];
    assign mosi_s       = mosi_sync_q[1];
    assign ss_n_s       = ss_sync_q[1];
    assign ss_active_o  = ~ss_n_s;
    assign ss_fall_o    = ss_prev_q & ~ss_n_s;
    assign sclk_rise    = sclk_s & ~sclk_prev_q & ss_active_o;
    assign sclk_fall    = ~sclk_s & sclk_prev_q & ss_active_o;
    assign byte_valid_o = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte_o    = {rx_q, mosi_s};
    assign miso_o       = tx_q[7] & ~ss_n_s;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        if (!ss_active_o) begin
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            tx_d      = 8'd0;
        end else if (ss_fall_o) begin
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            tx_d      = ID_BYTE;
        end else begin
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = {rx_q[5:0], mosi_s};
            end
            // A fall with the counter back at 0 follows a completed byte.
            if (sclk_fall) begin
                tx_d = (bit_cnt_q == 3'd0) ? tx_byte_i : {tx_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/panel_spi_target.sv
// Front-panel 7-segment SPI target: frame FSM, 16-digit register file, scan mux.
// Define PANEL_READBACK_EN to enable CMD_RD read frames.
module panel_spi_target
    import panel_pkg::*;
#(
    parameter int unsigned CLKFREQ = 50000000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic [7:0]  seg_o,
    output logic [1:0]  aux_o,
    output logic [15:0] dig_n_o,
    output logic        wr_stb_o,
    output logic [3:0]  wr_adr_o
);

    localparam logic [31:0] DIV_MAX = 32'(CLKFREQ / (SCAN_HZ * 16) - 1);
`ifdef PANEL_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic       ss_active, ss_fall, byte_valid;
    logic [7:0] rx_byte;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [3:0]  adr_q, adr_d;
    logic [7:0]  seg_q, seg_d;
    logic [7:0]  tx_next_q, tx_next_d;
    logic        wr_stb_q, wr_stb_d;
    logic [3:0]  wr_adr_q, wr_adr_d;
    logic        wr_en;
    digit_t      regs_q [16];
    logic [3:0]  idx_q, idx_d;
    logic [31:0] div_q, div_d;
    logic [7:0]  seg_out_q, seg_out_d;
    logic [1:0]  aux_out_q, aux_out_d;
    logic        tick;

    spi_target_shift u_shift (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sclk_i       (spi_sclk),
        .mosi_i       (spi_mosi),
        .ss_n_i       (spi_ss_n),
        .tx_byte_i    (tx_next_q),
        .miso_o       (spi_miso),
        .ss_active_o  (ss_active),
        .ss_fall_o    (ss_fall),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        adr_d     = adr_q;
        seg_d     = seg_q;
        tx_next_d = tx_next_q;
        wr_adr_d  = wr_adr_q;
        wr_stb_d  = 1'b0;
        wr_en     = 1'b0;
        if (!ss_active) begin
            state_d = S_IDLE;
        end else if (ss_fall) begin
            state_d = S_CMD;
        end else if (byte_valid) begin
            // tx_next holds the byte shifted out after the one now completing.
            case (state_q)
                S_CMD: begin
                    cmd_d     = rx_byte;
                    tx_next_d = rx_byte;
                    state_d   = S_ADR;
                end
                S_ADR: begin
                    adr_d     = rx_byte[3:0];
                    tx_next_d = rx_byte;
                    if (READBACK && cmd_q == CMD_RD) tx_next_d = regs_q[rx_byte[3:0]].seg;
                    state_d   = S_SEG;
                end
                S_SEG: begin
                    seg_d     = rx_byte;
                    tx_next_d = rx_byte;
                    if (READBACK && cmd_q == CMD_RD) tx_next_d = regs_q[adr_q].attr;
                    state_d   = S_ATTR;
                end
                S_ATTR: begin
                    tx_next_d = ID_BYTE;
                    state_d   = S_CMD;
                    if (cmd_q == CMD_WR) begin
                        wr_en    = 1'b1;
                        wr_stb_d = 1'b1;
                        wr_adr_d = adr_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // First cycle at a new index is blanked so the previous digit cannot ghost.
    always_comb begin
        tick      = (div_q == DIV_MAX);
        div_d     = tick ? 32'd0 : div_q + 32'd1;
        idx_d     = tick ? idx_q + 4'd1 : idx_q;
        seg_out_d = tick ? 8'd0 : regs_q[idx_q].seg;
        aux_out_d = tick ? 2'd0 : regs_q[idx_q].attr[1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'd0;
            adr_q     <= 4'd0;
            seg_q     <= 8'd0;
            tx_next_q <= 8'd0;
            wr_stb_q  <= 1'b0;
            wr_adr_q  <= 4'd0;
            idx_q     <= 4'd0;
            div_q     <= 32'd0;
            seg_out_q <= 8'd0;
            aux_out_q <= 2'd0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            adr_q     <= adr_d;
            seg_q     <= seg_d;
            tx_next_q <= tx_next_d;
            wr_stb_q  <= wr_stb_d;
            wr_adr_q  <= wr_adr_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            seg_out_q <= seg_out_d;
            aux_out_q <= aux_out_d;
            if (wr_en) regs_q[adr_q] <= '{seg: seg_q, attr: rx_byte};
        end
    end

    assign seg_o    = seg_out_q;
    assign aux_o    = aux_out_q;
    assign dig_n_o  = ~(16'd1 << idx_q);
    assign wr_stb_o = wr_stb_q;
    assign wr_adr_o = wr_adr_q;

endmodule

// File: tb/tb_panel_spi_target.sv
// Directed bench for panel_spi_target with a MISO byte scoreboard and a digit model.
module tb_panel_spi_target;
    import panel_pkg::*;

`ifdef PANEL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, spi_sclk, spi_mosi, spi_ss_n;
    logic        spi_miso, wr_stb_o;
    logic [7:0]  seg_o;
    logic [1:0]  aux_o;
    logic [15:0] dig_n_o;
    logic [3:0]  wr_adr_o;

    int compared   = 0;
    int mismatched = 0;
    int stb_count  = 0;
    logic [3:0] stb_adr = 4'd0;
    logic [7:0] exp_q[$];
    logic [7:0] m_seg[16];
    logic [7:0] m_attr[16];

    panel_spi_target #(.CLKFREQ(320000), .SCAN_HZ(1000)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_ss_n (spi_ss_n),
        .spi_miso (spi_miso),
        .seg_o    (seg_o),
        .aux_o    (aux_o),
        .dig_n_o  (dig_n_o),
        .wr_stb_o (wr_stb_o),
        .wr_adr_o (wr_adr_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb_o === 1'b1) begin
            stb_count++;
            stb_adr = wr_adr_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) spi_mosi = tx[7-i];
            repeat (5) @(negedge clk);
            spi_sclk = 1'b1;
            rx[7-i]  = spi_miso;
            repeat (5) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        @(negedge clk) spi_ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        @(negedge clk) spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input string tag);
        logic [7:0] b[4];
        logic [7:0] rx, e;
        logic       rd;
        b  = '{b0, b1, b2, b3};
        rd = RB && (b0 == CMD_RD);
        exp_q.push_back(ID_BYTE);
        exp_q.push_back(b0);
        exp_q.push_back(rd ? m_seg[b1[3:0]] : b1);
        exp_q.push_back(rd ? m_attr[b1[3:0]] : b2);
        for (int k = 0; k < 4; k++) begin
            xfer(b[k], 8, rx);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("%s miso byte%0d", tag, k), rx, e);
            end
        end
        if (b0 == CMD_WR) begin
            m_seg[b1[3:0]]  = b2;
            m_attr[b1[3:0]] = b3;
        end
    endtask

    task automatic check_digit(input int idx, input string tag);
        logic [15:0] tgt;
        int n;
        tgt = ~(16'd1 << idx);
        n   = 0;
        while (dig_n_o === tgt && n < 1000) begin @(negedge clk); n++; end
        while (dig_n_o !== tgt && n < 1000) begin @(negedge clk); n++; end
        chk({tag, " scan reached"}, 32'(n < 1000), 32'd1);
        chk({tag, " blank seg"}, seg_o, 8'd0);
        chk({tag, " blank aux"}, aux_o, 2'd0);
        @(negedge clk);
        chk({tag, " dig_n"}, dig_n_o, tgt);
        chk({tag, " seg"}, seg_o, m_seg[idx]);
        chk({tag, " aux"}, aux_o, m_attr[idx][1:0]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] rx;
        logic [7:0] segs[8];
        segs = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
        for (int i = 0; i < 16; i++) begin m_seg[i] = 8'd0; m_attr[i] = 8'd0; end
        rst_i = 1'b1; spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset seg_o", seg_o, 8'd0);
        chk("reset aux_o", aux_o, 2'd0);
        chk("reset dig_n_o", dig_n_o, 16'hFFFE);
        chk("reset wr_stb_o", wr_stb_o, 1'b0);
        chk("reset wr_adr_o", wr_adr_o, 4'd0);
        chk("reset miso", spi_miso, 1'b0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);

        // Single write frame.
        ss_low();
        s0 = stb_count;
        frame(8'h01, 8'h03, 8'h3F, 8'h01, "t1");
        repeat (4) @(negedge clk);
        chk("t1 strobes", stb_count - s0, 1);
        chk("t1 strobe adr", stb_adr, 4'd3);
        chk("t1 wr_adr_o", wr_adr_o, 4'd3);
        check_digit(3, "t1 d3");

        // Unknown command: consumed, no write.
        s0 = stb_count;
        frame(8'h7E, 8'h02, 8'hFF, 8'hFF, "t2");
        repeat (4) @(negedge clk);
        chk("t2 strobes", stb_count - s0, 0);
        ss_high();
        check_digit(2, "t2 d2");

        // Eight back-to-back frames under one ss.
        ss_low();
        s0 = stb_count;
        for (int i = 0; i < 8; i++)
            frame(8'h01, 8'(i), segs[i], 8'(i % 4), $sformatf("t3 f%0d", i));
        repeat (4) @(negedge clk);
        chk("t3 strobes", stb_count - s0, 8);
        ss_high();
        for (int i = 0; i < 8; i++) check_digit(i, $sformatf("t3 d%0d", i));

        // Abort after 13 bits, then a full frame.
        ss_low();
        s0 = stb_count;
        xfer(8'h01, 8, rx);
        chk("t4 abort miso byte0", rx, ID_BYTE);
        xfer(8'h05, 5, rx);
        ss_high();
        chk("t4 abort strobes", stb_count - s0, 0);
        check_digit(5, "t4 abort d5");
        ss_low();
        frame(8'h01, 8'h05, 8'h77, 8'h00, "t4");
        repeat (4) @(negedge clk);
        chk("t4 strobes", stb_count - s0, 1);
        ss_high();
        check_digit(5, "t4 d5");

        // Asynchronous reset in the middle of the seg byte.
        ss_low();
        xfer(8'h01, 8, rx);
        xfer(8'h06, 8, rx);
        xfer(8'hAA, 4, rx);
        #2 rst_i = 1'b1;
        #1;
        chk("t5 async seg_o", seg_o, 8'd0);
        chk("t5 async aux_o", aux_o, 2'd0);
        chk("t5 async dig_n_o", dig_n_o, 16'hFFFE);
        chk("t5 async wr_stb_o", wr_stb_o, 1'b0);
        chk("t5 async wr_adr_o", wr_adr_o, 4'd0);
        chk("t5 async miso", spi_miso, 1'b0);
        spi_ss_n = 1'b1; spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin m_seg[i] = 8'd0; m_attr[i] = 8'd0; end
        exp_q.delete();
        repeat (4) @(negedge clk);
        ss_low();
        s0 = stb_count;
        frame(8'h01, 8'h0A, 8'h39, 8'h02, "t5");
        repeat (4) @(negedge clk);
        chk("t5 strobes", stb_count - s0, 1);
        chk("t5 wr_adr_o", wr_adr_o, 4'hA);
        ss_high();
        check_digit(10, "t5 d10");
        check_digit(6, "t5 d6");

        // Write then read back reg 9.
        ss_low();
        s0 = stb_count;
        frame(8'h01, 8'h09, 8'h6D, 8'h02, "t6 wr");
        frame(8'h02, 8'h09, 8'h00, 8'h00, "t6 rd");
        repeat (4) @(negedge clk);
        chk("t6 strobes", stb_count - s0, 1);
        ss_high();
        check_digit(9, "t6 d9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/panel_spi_target.md
Name: panel_spi_target

Overview:
- SPI responder for the front-panel 7-segment display bus.
- Receives 4-byte write frames {cmd, adr, seg, attr} from the panel-display SPI master and stores them in a 16-entry digit register file.
- Continuously time-multiplexes the stored digits onto common-cathode segment/digit pins.
- Sits in the panel FPGA/CPLD behind one seg_ss line; all logic runs on the single system clock, with SPI pins oversampled.

Parameters:
- CLKFREQ, 50000000, system clock frequency in Hz.
- SCAN_HZ, 1000, full refresh rate of all 16 digits.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- spi_sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- spi_mosi  in  1  master-out data, MSB first.
- spi_ss_n  in  1  chip select, active-low.
- spi_miso  out  1  responder-out data.
- seg_o  out  8  segment drive for the currently scanned digit (seg byte), active-high.
- aux_o  out  2  attr[1:0] (bit0 tick, bit1 colon) of the scanned digit.
- dig_n_o  out  16  digit enables, one-hot active-low.
- wr_stb_o  out  1  one-cycle pulse when a frame commits.
- wr_adr_o  out  4  register index of the last commit.

Behaviour:
- Reset values:
  - spi_miso=0, seg_o=0, aux_o=0, dig_n_o=16'hFFFE, wr_stb_o=0, wr_adr_o=0.
  - All registers 0, scan index 0, byte/bit counters 0, state S_IDLE.
- Input synchronisation and sampling:
  - spi_sclk, spi_mosi and spi_ss_n each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised copies.
  - SCLK frequency must be ≤ CLKFREQ/8.
  - MOSI is sampled on the synchronised SCLK rising edge and shifted MSB first.
- MISO:
  - Updates on the synchronised SCLK falling edge.
  - The first bit is presented on the cycle after ss falls (synchronised).
  - spi_miso=0 whenever ss is high.
- Frame structure:
  - After ss asserts, bytes are counted mod 4: byte 0 is cmd, 1 is adr, 2 is seg, 3 is attr.
  - Frames are back-to-back under one ss assertion (the master holds ss across all 8 digits); the counter wraps 3→0.
- FSM states:
  - S_IDLE: ss high. On ss fall → S_CMD.
  - S_CMD, S_ADR, S_SEG, S_ATTR: each advances to the next state after 8 bits; S_ATTR → S_CMD.
- Commit rules:
  - cmd==8'h01 (CMD_WR) commits on completion of the attr byte: reg[adr[3:0]] <= {seg, attr}.
  - wr_stb_o pulses in the cycle after the 8th attr bit is sampled; wr_adr_o is updated in that cycle.
  - adr[7:4] are ignored.
  - Any other cmd: the frame is consumed, nothing is written, and no strobe is issued.
- MISO data:
  - Byte 0 of every frame returns ID_BYTE=8'h5A.
  - Bytes 1–3 return the previously received byte (one-byte delayed echo).
- ss boundary conditions:
  - ss rising mid-byte or mid-frame aborts: partial bits are dropped, there is no commit, and the FSM returns to S_IDLE.
  - The next ss fall restarts at byte 0.
- Scan:
  - The divider counts to CLKFREQ/(SCAN_HZ*16)-1, then the 4-bit scan index increments and wraps 15→0.
  - dig_n_o = ~(1<<idx). seg_o and aux_o are registered from reg[idx].
  - Outputs are blanked (seg_o=0, aux_o=0) for the first cycle after each index change (anti-ghosting).
- Write/scan collision:
  - A write to the register being scanned takes effect on the next cycle's outputs; there is no tearing, since both bytes are written atomically.
- Async reset mid-frame:
  - Everything returns to reset values immediately; the frame in progress is lost.

Optional Feature:
- Macro: PANEL_READBACK_EN.
- Defined:
  - cmd==8'h02 (CMD_RD) is a read frame.
  - After the adr byte, byte 2 returns reg[adr].seg and byte 3 returns reg[adr].attr on MISO.
  - There is no commit and no strobe.
- Undefined:
  - 8'h02 is an unknown command; bytes 2–3 return the delayed echo.

Decomposition:
- Package panel_pkg:
  - CMD_WR, CMD_RD, ID_BYTE constants.
  - Frame state enum (S_IDLE, S_CMD, S_ADR, S_SEG, S_ATTR).
  - digit_t packed struct {seg[7:0], attr[7:0]}.
- One sub-module, spi_target_shift:
  - Synchronisers, edge detect, bit counter, rx shift register.
  - Emits byte_valid and rx_byte; loads a tx byte.
  - Clears on ss deassert.
- Frame FSM, register file and scan logic stay in the top module.

Test Plan:
- Reset, then SPI frame 01 03 3F 01 with ss held low → wr_stb_o pulses once, wr_adr_o=3. When idx=3: seg_o=8'h3F, aux_o=2'b01, dig_n_o=16'hFFF7.
- Eight back-to-back frames under one ss (adr 0..7, seg 06,5B,4F,66,6D,7D,07,7F) → 8 strobes, registers 0–7 hold those values. MISO byte 0 of each frame = 5A, byte 1 = 01.
- Frame with cmd 8'h7E, adr 02, seg FF, attr FF → no strobe, reg[2] unchanged (0).
- ss raised after 13 bits of frame 01 05 77 00 → no commit. The next full frame 01 05 77 00 commits reg[5]=7700.
- Assert rst_i asynchronously mid-seg-byte → all outputs return to reset values without a clock edge. A following frame commits normally.
- With PANEL_READBACK_EN, after writing reg[9]=6D02, read frame 02 09 00 00 → MISO returns 5A, 02, 6D, 02 and no strobe. Without the macro → MISO returns 5A, 02, 09, 00.
